// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
// Entry layout is {pc, instr, ds, exc}.
package fd_pkg;

    localparam int EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             ds;
        logic [EXC_W-1:0] exc;
    } fd_entry_t;

    // A single-entry queue still needs a one-bit pointer to index storage.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fd_queue_reg_if.sv
// Handshake and payload bundle between fetch, the F/D queue and decode.
// slave = queue view, master = the fetch/decode environment view.
interface fd_queue_reg_if;
    import fd_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             F_DelaySlot;
    logic [EXC_W-1:0] F_EXCcode;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      pc_out;
    logic [31:0]      instr_out;
    logic             D_DelaySlot;
    logic [EXC_W-1:0] temp_D_EXCcode;

    modport slave (
        input  in_valid, pc, instr, F_DelaySlot, F_EXCcode, out_ready,
        output in_ready, out_valid, pc_out, instr_out, D_DelaySlot, temp_D_EXCcode
    );

    modport master (
        output in_valid, pc, instr, F_DelaySlot, F_EXCcode, out_ready,
        input  in_ready, out_valid, pc_out, instr_out, D_DelaySlot, temp_D_EXCcode
    );

endinterface

// File: rtl/fdq_store.sv
// DEPTH x entry register array: one synchronous write port, one async read port.
// No reset on data; validity is tracked by the owner's count.
module fdq_store
    import fd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fd_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output fd_entry_t        rdata
);

    fd_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fd_queue_reg.sv
// In-order DEPTH-entry F/D queue with valid/ready on both sides; req flushes to a
// HANDLER_PC bubble. Optional empty-queue bypass under macro FDQ_BYPASS_EN.
module fd_queue_reg
    import fd_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    fd_queue_reg_if.slave   fd
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0] count_q,     count_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [31:0]      bubble_pc_q, bubble_pc_d;

    fd_entry_t head;
    fd_entry_t f_entry;
    fd_entry_t out_entry;
    logic      empty;
    logic      in_rdy;
    logic      out_vld;
    logic      bypass;
    logic      bypass_take;
    logic      push;
    logic      pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    fdq_store #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_store (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (f_entry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        f_entry = '{pc: fd.pc, instr: fd.instr, ds: fd.F_DelaySlot, exc: fd.F_EXCcode};
        empty   = (count_q == '0);
        in_rdy  = (count_q != DEPTH_C);
        bypass  = 1'b0;
`ifdef FDQ_BYPASS_EN
        bypass  = empty & fd.in_valid & ~req;
`endif
        out_vld     = ~empty | bypass;
        bypass_take = bypass & fd.out_ready;
        // A bypassed entry that decode takes right away never touches storage.
        push = fd.in_valid & in_rdy & ~req & ~bypass_take;
        pop  = ~empty & fd.out_ready & ~req;

        if (!empty) begin
            out_entry = head;
        end else if (bypass) begin
            out_entry = f_entry;
        end else begin
            out_entry = '{pc: bubble_pc_q, instr: 32'h0, ds: 1'b0, exc: EXC_NONE};
        end
    end

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        bubble_pc_d = bubble_pc_q;

        if (req) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            bubble_pc_d = HANDLER_PC;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d    = ptr_inc(rd_ptr_q);
                bubble_pc_d = head.pc;
            end else if (bypass_take) begin
                bubble_pc_d = fd.pc;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bubble_pc_q <= RESET_PC;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bubble_pc_q <= bubble_pc_d;
        end
    end

    assign fd.in_ready       = in_rdy;
    assign fd.out_valid      = out_vld;
    assign fd.pc_out         = out_entry.pc;
    assign fd.instr_out      = out_entry.instr;
    assign fd.D_DelaySlot    = out_entry.ds;
    assign fd.temp_D_EXCcode = out_entry.exc;

endmodule

// File: tb/tb_fd_queue_reg.sv
// Directed plus random stimulus for fd_queue_reg against a queue-based reference model.
module tb_fd_queue_reg;
    import fd_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    logic req;

    always #5 clk = ~clk;

    fd_queue_reg_if fd_if ();

    fd_queue_reg #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .fd    (fd_if)
    );

    int checks   = 0;
    int failures = 0;

    fd_entry_t   mq[$];
    logic [31:0] m_bubble = RESET_PC_DEF;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] p, input logic [31:0] ins,
                         input logic ds, input logic [4:0] exc, input logic ordy, input logic rq);
        fd_if.in_valid    = iv;
        fd_if.pc          = p;
        fd_if.instr       = ins;
        fd_if.F_DelaySlot = ds;
        fd_if.F_EXCcode   = exc;
        fd_if.out_ready   = ordy;
        req               = rq;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input bit chk);
        fd_entry_t e;
        fd_entry_t f;
        logic      e_valid;
        bit        byp;
        bit        was_full;
        @(negedge clk);
        f   = '{pc: fd_if.pc, instr: fd_if.instr, ds: fd_if.F_DelaySlot, exc: fd_if.F_EXCcode};
        byp = 1'b0;
`ifdef FDQ_BYPASS_EN
        byp = (mq.size() == 0) && fd_if.in_valid && !req;
`endif
        if (mq.size() != 0) begin
            e = mq[0];
            e_valid = 1'b1;
        end else if (byp) begin
            e = f;
            e_valid = 1'b1;
        end else begin
            e = '{pc: m_bubble, instr: 32'h0, ds: 1'b0, exc: 5'd0};
            e_valid = 1'b0;
        end
        if (chk) begin
            check_val("in_ready",  32'(fd_if.in_ready), 32'(mq.size() != DEPTH));
            check_val("out_valid", 32'(fd_if.out_valid), 32'(e_valid));
            check_val("pc_out",    fd_if.pc_out, e.pc);
            check_val("instr_out", fd_if.instr_out, e.instr);
            check_val("ds_out",    32'(fd_if.D_DelaySlot), 32'(e.ds));
            check_val("exc_out",   32'(fd_if.temp_D_EXCcode), 32'(e.exc));
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_bubble = RESET_PC_DEF;
        end else if (req) begin
            mq.delete();
            m_bubble = HANDLER_PC_DEF;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (e_valid && fd_if.out_ready) begin
                if (mq.size() != 0) m_bubble = mq.pop_front().pc;
                else                m_bubble = f.pc;
            end
            if (fd_if.in_valid && !was_full && !(byp && fd_if.out_ready))
                mq.push_back(f);
        end
        #1;
    endtask

    initial begin
        logic [4:0] exc_tab [3];
        exc_tab[0] = EXC_NONE;
        exc_tab[1] = EXC_ADEL;
        exc_tab[2] = EXC_RI;

        reset = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
        #1;
        cycle(0);
        cycle(0);
        reset = 1'b0;

        // Idle after reset.
        cycle(1);
        cycle(1);

        // Fill with decode stalled, hold a third offer, then drain in order.
        drive(1, 32'h3000, 32'h2401_0001, 0, 0, 0, 0); cycle(1);
        drive(1, 32'h3004, 32'h2402_0002, 0, 0, 0, 0); cycle(1);
        drive(1, 32'h3008, 32'h2403_0003, 0, 0, 0, 0); cycle(1);
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (3) cycle(1);

        // Full queue with offer and pop together: no push, in_ready rises after.
        drive(1, 32'h3010, 32'h1111_0000, 0, 0, 0, 0); cycle(1);
        drive(1, 32'h3014, 32'h1111_0004, 0, 0, 0, 0); cycle(1);
        drive(1, 32'h3018, 32'h1111_0008, 0, 0, 1, 0); cycle(1);
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);            cycle(1);
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (2) cycle(1);

        // Flush while full, with an offer in the same cycle.
        drive(1, 32'h3020, 32'h2222_0000, 0, 0, 0, 0); cycle(1);
        drive(1, 32'h3024, 32'h2222_0004, 0, 0, 0, 0); cycle(1);
        drive(1, 32'h3028, 32'h2222_0008, 0, 0, 1, 1); cycle(1);
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (2) cycle(1);

        // Exception code and delay-slot flag pass through.
        drive(1, 32'h3030, 32'h0000_000c, 1, EXC_ADEL, 0, 0); cycle(1);
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (2) cycle(1);

        // Wrap: 2*DEPTH+1 back-to-back entries with decode always ready.
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            drive(1, 32'h5000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), i[0], 5'(i), 1, 0);
            cycle(1);
        end
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (2) cycle(1);

        // Single offer into an empty queue with decode ready.
        drive(1, 32'h3008, 32'h2403_0003, 0, 0, 1, 0); cycle(1);
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        repeat (2) cycle(1);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
                  exc_tab[$urandom_range(0, 2)], $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
            cycle(1);
        end

        // Reset mid-traffic returns to the reset bubble.
        drive(1, 32'h7000, 32'h7777_7777, 0, 0, 0, 0); cycle(1);
        reset = 1'b1;
        cycle(0);
        reset = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
        cycle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
